sys_ctrl_cmd: RTL and testbench

Command decoder and sequencer on the receive side of the system controller. It consumes synchronized bytes from the UART receiver (via the data synchronizer) in the `CLK` domain and parses four command frames: register write, register read, ALU with operands, and ALU without operands. It drives the register file and ALU accordingly, and pushes results into the TX async FIFO for the UART transmitter.

---
 rtl/sys_ctrl_cmd_pkg.sv | 40 ++++
 rtl/sys_ctrl_cmd_if.sv | 36 +++
 rtl/sys_ctrl_cmd.sv | 169 ++++++++++++++++
 tb/tb_sys_ctrl_cmd.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_cmd_pkg.sv
// Shared definitions for the receive-side command sequencer: command bytes,
// FSM encoding and the fixed ALU operand register addresses.
package sys_ctrl_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int ADDR_OPA = 0;
    localparam int ADDR_OPB = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_PUSH,
        ST_PUSH_HI
    } state_e;

    // First state of a frame for a given command byte; unknown bytes stay in IDLE.
    function automatic state_e cmd_decode(input logic [7:0] b);
        state_e s;
        case (b)
            CMD_WR:      s = ST_WR_ADDR;
            CMD_RD:      s = ST_RD_ADDR;
            CMD_ALU_OP:  s = ST_ALU_A;
            CMD_ALU_NOP: s = ST_ALU_FUN;
            default:     s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sys_ctrl_cmd_if.sv
// Signal bundle between the command sequencer (master) and its environment:
// RX byte stream, register file, ALU and TX FIFO.
interface sys_ctrl_cmd_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FUNC_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_Valid;
    logic [ALU_WIDTH-1:0]  ALU_OUT;
    logic                  OUT_Valid;
    logic                  FIFO_FULL;

    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  ALU_EN;
    logic [FUNC_WIDTH-1:0] ALU_FUN;
    logic                  CLK_EN;
    logic                  WR_INC;
    logic [DATA_WIDTH-1:0] WR_DATA;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, WR_INC, WR_DATA
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, WR_INC, WR_DATA
    );
endinterface

// File: rtl/sys_ctrl_cmd.sv
// Command decoder/sequencer: parses RX frames into regfile writes/reads and ALU ops, pushes results.
// Latency: every strobe is registered, one cycle after the byte or valid pulse that triggers it.
// Backpressure: FIFO_FULL holds the push states; RX bytes outside byte-expecting states are dropped.
module sys_ctrl_cmd
    import sys_ctrl_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FUNC_WIDTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    sys_ctrl_cmd_if.master bus
);

    state_e                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wrdata_q,   wrdata_d;
    logic                  wren_q,     wren_d;
    logic                  rden_q,     rden_d;
    logic                  alu_en_q,   alu_en_d;
    logic                  clk_en_q,   clk_en_d;
    logic [FUNC_WIDTH-1:0] alu_fun_q,  alu_fun_d;
    logic                  wr_inc_q,   wr_inc_d;
    logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;
    logic [ALU_WIDTH-1:0]  result_q,   result_d;
    logic                  single_q,   single_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wrdata_d  = wrdata_q;
        wren_d    = 1'b0;
        rden_d    = 1'b0;
        alu_en_d  = alu_en_q;
        clk_en_d  = clk_en_q;
        alu_fun_d = alu_fun_q;
        wr_inc_d  = 1'b0;
        wr_data_d = wr_data_q;
        result_d  = result_q;
        single_d  = single_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.RX_D_VLD) begin
                    state_d = cmd_decode(bus.RX_P_DATA[7:0]);
                end
            end
            ST_WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wrdata_d = bus.RX_P_DATA;
                    wren_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    rden_d  = 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus.RdData_Valid) begin
                    result_d = ALU_WIDTH'(bus.RdData);
                    single_d = 1'b1;
                    state_d  = ST_PUSH;
                end
            end
            ST_ALU_A: begin
                if (bus.RX_D_VLD) begin
                    addr_d   = ADDR_WIDTH'(ADDR_OPA);
                    wrdata_d = bus.RX_P_DATA;
                    wren_d   = 1'b1;
                    state_d  = ST_ALU_B;
                end
            end
            ST_ALU_B: begin
                if (bus.RX_D_VLD) begin
                    addr_d   = ADDR_WIDTH'(ADDR_OPB);
                    wrdata_d = bus.RX_P_DATA;
                    wren_d   = 1'b1;
                    state_d  = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (bus.RX_D_VLD) begin
                    alu_fun_d = bus.RX_P_DATA[FUNC_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    clk_en_d  = 1'b1;
                    state_d   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                // ALU stays enabled and clocked until it reports a result.
                if (bus.OUT_Valid) begin
                    result_d = bus.ALU_OUT;
                    single_d = 1'b0;
                    alu_en_d = 1'b0;
                    clk_en_d = 1'b0;
                    state_d  = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (!bus.FIFO_FULL) begin
                    wr_inc_d  = 1'b1;
                    wr_data_d = result_q[DATA_WIDTH-1:0];
                    state_d   = single_q ? ST_IDLE : ST_PUSH_HI;
                end
            end
            ST_PUSH_HI: begin
                if (!bus.FIFO_FULL) begin
                    wr_inc_d  = 1'b1;
                    wr_data_d = result_q[ALU_WIDTH-1:DATA_WIDTH];
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wrdata_q  <= '0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            alu_en_q  <= 1'b0;
            clk_en_q  <= 1'b0;
            alu_fun_q <= '0;
            wr_inc_q  <= 1'b0;
            wr_data_q <= '0;
            result_q  <= '0;
            single_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wrdata_q  <= wrdata_d;
            wren_q    <= wren_d;
            rden_q    <= rden_d;
            alu_en_q  <= alu_en_d;
            clk_en_q  <= clk_en_d;
            alu_fun_q <= alu_fun_d;
            wr_inc_q  <= wr_inc_d;
            wr_data_q <= wr_data_d;
            result_q  <= result_d;
            single_q  <= single_d;
        end
    end

    assign bus.WrEn    = wren_q;
    assign bus.RdEn    = rden_q;
    assign bus.Address = addr_q;
    assign bus.WrData  = wrdata_q;
    assign bus.ALU_EN  = alu_en_q;
    assign bus.CLK_EN  = clk_en_q;
    assign bus.ALU_FUN = alu_fun_q;
    assign bus.WR_INC  = wr_inc_q;
    assign bus.WR_DATA = wr_data_q;

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Bench for sys_ctrl_cmd: table of frames with expected strobes, scoreboard of
// register-file / FIFO events, plus hand sequences for backpressure, discards and reset.
`timescale 1ns/1ps
module tb_sys_ctrl_cmd;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    sys_ctrl_cmd_if #(.DATA_WIDTH(8), .ALU_WIDTH(16), .ADDR_WIDTH(4), .FUNC_WIDTH(4)) bus ();

    sys_ctrl_cmd #(.DATA_WIDTH(8), .ALU_WIDTH(16), .ADDR_WIDTH(4), .FUNC_WIDTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_PUSH = 2'd2;

    typedef struct packed {
        logic [2:0]      nb;
        logic [3:0][7:0] bytes;
        logic [15:0]     resp;
        logic [3:0]      fun;
        logic [2:0]      ne;
        ev_t [3:0]       ev;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[6];
    int   n_chk   = 0;
    int   n_err   = 0;
    int   inc_cnt = 0;

    function automatic ev_t mkev(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [15:0] resp, input logic [3:0] fun, input int ne,
                                input ev_t e0, input ev_t e1, input ev_t e2, input ev_t e3);
        vec_t v;
        v.nb = 3'(nb);
        v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = b2; v.bytes[3] = b3;
        v.resp = resp;
        v.fun  = fun;
        v.ne   = 3'(ne);
        v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2; v.ev[3] = e3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_ev(input ev_t act, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: unexpected event %h, none expected", name, act);
        end else begin
            e = exp_q.pop_front();
            chk(name, 32'(act), 32'(e));
        end
    endtask

    // Scoreboard side: every strobe must match the next queued expectation.
    always @(negedge CLK) begin
        if (RST) begin
            if (bus.WR_INC) inc_cnt++;
            if (bus.WrEn)   note_ev(mkev(K_WR, bus.Address, bus.WrData), "wr_strobe");
            if (bus.RdEn)   note_ev(mkev(K_RD, bus.Address, 8'h00), "rd_strobe");
            if (bus.WR_INC) note_ev(mkev(K_PUSH, 4'h0, bus.WR_DATA), "push_strobe");
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        bus.RdData       = d;
        bus.RdData_Valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.RdData_Valid = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] r);
        bus.ALU_OUT   = r;
        bus.OUT_Valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.OUT_Valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) idle(1);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        idle(2);
    endtask

    task automatic chk_zero(input string name);
        chk(name, 32'({bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.ALU_EN,
                       bus.ALU_FUN, bus.CLK_EN, bus.WR_INC, bus.WR_DATA}), 32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        for (int i = 0; i < int'(v.ne); i++) exp_q.push_back(v.ev[i]);
        for (int i = 0; i < int'(v.nb); i++) send_byte(v.bytes[i]);
        if (v.bytes[0] == 8'hBB) begin
            chk($sformatf("v%0d_rden_rise", idx), 32'(bus.RdEn), 32'd1);
            idle(2);
            pulse_rd(v.resp[7:0]);
        end else if (v.bytes[0] == 8'hCC || v.bytes[0] == 8'hDD) begin
            chk($sformatf("v%0d_alu_en_rise", idx),
                32'({bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN}), 32'({2'b11, v.fun}));
            idle(3);
            chk($sformatf("v%0d_alu_en_hold", idx), 32'({bus.ALU_EN, bus.CLK_EN}), 32'd3);
            pulse_alu(v.resp);
            chk($sformatf("v%0d_alu_en_drop", idx), 32'({bus.ALU_EN, bus.CLK_EN}), 32'd0);
        end
        wait_drain($sformatf("v%0d_drain", idx));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        ev_t z;
        z = '0;
        vecs[0] = mk(3, 8'hAA, 8'h00, 8'h05, 8'h00, 16'h0000, 4'h0, 1,
                     mkev(K_WR, 4'h0, 8'h05), z, z, z);
        vecs[1] = mk(2, 8'hBB, 8'h02, 8'h00, 8'h00, 16'h003C, 4'h0, 2,
                     mkev(K_RD, 4'h2, 8'h00), mkev(K_PUSH, 4'h0, 8'h3C), z, z);
        vecs[2] = mk(4, 8'hCC, 8'h04, 8'h03, 8'h01, 16'h0001, 4'h1, 4,
                     mkev(K_WR, 4'h0, 8'h04), mkev(K_WR, 4'h1, 8'h03),
                     mkev(K_PUSH, 4'h0, 8'h01), mkev(K_PUSH, 4'h0, 8'h00));
        vecs[3] = mk(2, 8'hDD, 8'h00, 8'h00, 8'h00, 16'h1207, 4'h0, 2,
                     mkev(K_PUSH, 4'h0, 8'h07), mkev(K_PUSH, 4'h0, 8'h12), z, z);
        vecs[4] = mk(3, 8'hAA, 8'h1F, 8'hA5, 8'h00, 16'h0000, 4'h0, 1,
                     mkev(K_WR, 4'hF, 8'hA5), z, z, z);
        vecs[5] = mk(2, 8'hDD, 8'h0F, 8'h00, 8'h00, 16'hFFFF, 4'hF, 2,
                     mkev(K_PUSH, 4'h0, 8'hFF), mkev(K_PUSH, 4'h0, 8'hFF), z, z);

        bus.RX_P_DATA = '0; bus.RX_D_VLD = 1'b0; bus.RdData = '0; bus.RdData_Valid = 1'b0;
        bus.ALU_OUT = '0; bus.OUT_Valid = 1'b0; bus.FIFO_FULL = 1'b0;
        RST = 1'b0;
        idle(3);
        chk_zero("reset_state");
        RST = 1'b1;
        idle(1);

        send_byte(8'h55);
        idle(3);
        chk_zero("invalid_byte");

        for (int i = 0; i < 6; i++) run_vec(i);

        // Stray valid pulses in IDLE must not trigger a push.
        c0 = inc_cnt;
        pulse_rd(8'h99);
        pulse_alu(16'h9999);
        idle(4);
        chk("stray_valid_idle", 32'(inc_cnt - c0), 32'd0);

        // Bytes and OUT_Valid during RD_WAIT are dropped; only RdData is pushed.
        exp_q.push_back(mkev(K_RD, 4'h5, 8'h00));
        exp_q.push_back(mkev(K_PUSH, 4'h0, 8'h77));
        send_byte(8'hBB);
        send_byte(8'h05);
        send_byte(8'hAA);
        send_byte(8'h01);
        pulse_alu(16'hEEEE);
        pulse_rd(8'h77);
        wait_drain("rd_wait_discard");

        // FIFO full holds both pushes until it clears.
        exp_q.push_back(mkev(K_PUSH, 4'h0, 8'hCD));
        exp_q.push_back(mkev(K_PUSH, 4'h0, 8'hAB));
        bus.FIFO_FULL = 1'b1;
        send_byte(8'hDD);
        send_byte(8'h03);
        idle(1);
        c0 = inc_cnt;
        pulse_alu(16'hABCD);
        idle(5);
        chk("full_no_push", 32'(inc_cnt - c0), 32'd0);
        chk("full_pending", 32'(exp_q.size()), 32'd2);
        bus.FIFO_FULL = 1'b0;
        wait_drain("full_drain");
        chk("full_push_count", 32'(inc_cnt - c0), 32'd2);

        // Reset between command and address aborts the frame.
        send_byte(8'hAA);
        RST = 1'b0;
        #1;
        chk_zero("mid_frame_reset");
        idle(2);
        RST = 1'b1;
        idle(1);
        c0 = inc_cnt;
        send_byte(8'h00);
        send_byte(8'h05);
        idle(3);
        chk("aborted_frame_quiet", 32'({bus.WrEn, 8'(inc_cnt - c0)}), 32'd0);
        run_vec(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
